// File: rtl/reg_access_sequencer.sv
// Register-file initiator: reads two operands for one decoded instruction, hands them to the ALU,
// and writes the ALU result back through busD with a single registered regWeD strobe.
module reg_access_sequencer #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] rd,
    input  logic              use_a,
    input  logic              use_b,
    input  logic              wb_en,
    output logic [ADDR_W-1:0] regAddrA,
    output logic [ADDR_W-1:0] regAddrB,
    output logic [ADDR_W-1:0] regAddrD,
    output logic              regReA,
    output logic              regReB,
    output logic              regWeD,
    input  logic [DATA_W-1:0] busA,
    input  logic [DATA_W-1:0] busB,
    output logic [DATA_W-1:0] busD,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    input  logic              op_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPTURE,
        ISSUE,
        WAIT_RES,
        WSETUP,
        WSTROBE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] rsAQ;
    logic [ADDR_W-1:0] rsBQ;
    logic [ADDR_W-1:0] rdQ;
    logic              useAQ;
    logic              useBQ;
    logic              wbEnQ;

    // Every output is set on the transition into the state that owns it, so all are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_ready <= 1'b0;
            rsAQ        <= '0;
            rsBQ        <= '0;
            rdQ         <= '0;
            useAQ       <= 1'b0;
            useBQ       <= 1'b0;
            wbEnQ       <= 1'b0;
            regAddrA    <= '0;
            regAddrB    <= '0;
            regAddrD    <= '0;
            regReA      <= 1'b0;
            regReB      <= 1'b0;
            regWeD      <= 1'b0;
            busD        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_valid    <= 1'b0;
            res_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!instr_ready) begin
                        instr_ready <= 1'b1;
                    end else if (instr_valid) begin
                        rsAQ        <= rs_a;
                        rsBQ        <= rs_b;
                        rdQ         <= rd;
                        useAQ       <= use_a;
                        useBQ       <= use_b;
                        wbEnQ       <= wb_en;
                        regAddrA    <= rs_a;
                        regAddrB    <= rs_b;
                        regReA      <= use_a;
                        regReB      <= use_b;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // r0 always reads as zero regardless of what the bus carries.
                    op_a     <= (useAQ && rsAQ != '0) ? busA : '0;
                    op_b     <= (useBQ && rsBQ != '0) ? busB : '0;
                    regReA   <= 1'b0;
                    regReB   <= 1'b0;
                    op_valid <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_ready <= 1'b0;
                        if (wbEnQ && rdQ != '0) begin
                            regAddrD <= rdQ;
                            busD     <= res_data;
                            state    <= WSETUP;
                        end else begin
                            instr_ready <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                WSETUP: begin
                    regWeD <= 1'b1;
                    state  <= WSTROBE;
                end
                WSTROBE: begin
                    regWeD      <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed bench for reg_access_sequencer with a behavioural register file and hand-driven ALU handshake.
module tb_reg_access_sequencer;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] rs_a;
    logic [AW-1:0] rs_b;
    logic [AW-1:0] rd;
    logic          use_a;
    logic          use_b;
    logic          wb_en;
    logic [AW-1:0] regAddrA;
    logic [AW-1:0] regAddrB;
    logic [AW-1:0] regAddrD;
    logic          regReA;
    logic          regReB;
    logic          regWeD;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;
    logic [DW-1:0] busD;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          op_valid;
    logic          op_ready;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_ready;

    logic [DW-1:0] mem [32];

    int nAssert = 0;
    int nFail   = 0;

    // Observations recorded by runInstr
    logic          obsReA, obsReB, obsOpValid3, obsOpValidAfter, obsResReady, obsReadyAfterRes;
    logic [AW-1:0] obsAddrA;
    logic [DW-1:0] obsOpA, obsOpB, weData, postData, lastBusD;
    logic [AW-1:0] weAddr, postAddr, lastAddrD;
    logic          postReady, stableOk, readyBusy, reBSeen, weStable, overlap;
    int            strobes;

    reg_access_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .rs_a(rs_a), .rs_b(rs_b), .rd(rd),
        .use_a(use_a), .use_b(use_b), .wb_en(wb_en),
        .regAddrA(regAddrA), .regAddrB(regAddrB), .regAddrD(regAddrD),
        .regReA(regReA), .regReB(regReB), .regWeD(regWeD),
        .busA(busA), .busB(busB), .busD(busD),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file read ports: driven only while enabled, r0 reads zero.
    assign busA = regReA ? ((regAddrA == '0) ? '0 : mem[regAddrA]) : 'z;
    assign busB = regReB ? ((regAddrB == '0) ? '0 : mem[regAddrB]) : 'z;

    // One cycle, observed at the falling edge; also models the register-file write.
    task automatic step();
        @(negedge clk);
        if (regReB === 1'b1) reBSeen = 1'b1;
        if (regWeD === 1'b1) begin
            strobes++;
            weAddr = regAddrD;
            weData = busD;
            if (regAddrD !== lastAddrD || busD !== lastBusD) weStable = 1'b0;
            if (regReA === 1'b1 || regReB === 1'b1) overlap = 1'b1;
            if (regAddrD != '0) mem[regAddrD] = busD;
        end
        lastAddrD = regAddrD;
        lastBusD  = busD;
    endtask

    task automatic runInstr(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic [AW-1:0] rdv,
                            input logic ua, input logic ub, input logic wb, input logic [DW-1:0] res,
                            input int hold, input bit stopAtStrobe);
        int t;
        strobes = 0; stableOk = 1'b1; readyBusy = 1'b0; reBSeen = 1'b0; weStable = 1'b1; overlap = 1'b0;
        t = 0;
        while (instr_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (instr_ready !== 1'b1) begin
            nAssert++; nFail++;
            $display("FAIL instr_ready_timeout: got %b expected 1", instr_ready);
        end
        rs_a = ra; rs_b = rb; rd = rdv; use_a = ua; use_b = ub; wb_en = wb; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        obsReA = regReA; obsReB = regReB; obsAddrA = regAddrA;
        step();
        step();
        obsOpValid3 = op_valid; obsOpA = op_a; obsOpB = op_b;
        for (int i = 0; i < hold; i++) begin
            instr_valid = 1'b1; rs_a = ~ra; rs_b = ~rb;
            step();
            if (op_valid !== 1'b1 || op_a !== obsOpA || op_b !== obsOpB) stableOk = 1'b0;
            if (instr_ready !== 1'b0) readyBusy = 1'b1;
        end
        instr_valid = 1'b0;
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        obsOpValidAfter = op_valid; obsResReady = res_ready;
        res_valid = 1'b1; res_data = res;
        step();
        res_valid = 1'b0;
        obsReadyAfterRes = instr_ready;
        for (int i = 0; i < 3; i++) begin
            step();
            if (stopAtStrobe && regWeD === 1'b1) return;
            if (i == 1) begin
                postAddr = regAddrD; postData = busD; postReady = instr_ready;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; rs_a = '0; rs_b = '0; rd = '0;
        use_a = 1'b0; use_b = 1'b0; wb_en = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3] = 16'h1234; mem[5] = 16'h00FF;
        lastAddrD = '0; lastBusD = '0;
        step(); step();
        nAssert++;
        if ({instr_ready, regReA, regReB, regWeD, op_valid, res_ready} !== 6'b0) begin
            nFail++; $display("FAIL reset_ctrl: got %b expected 000000",
                {instr_ready, regReA, regReB, regWeD, op_valid, res_ready});
        end
        nAssert++;
        if ({regAddrA, regAddrB, regAddrD} !== 15'h0) begin
            nFail++; $display("FAIL reset_addr: got %h expected 0000", {regAddrA, regAddrB, regAddrD});
        end
        nAssert++;
        if ({busD, op_a, op_b} !== 48'h0) begin
            nFail++; $display("FAIL reset_data: got %h expected 0", {busD, op_a, op_b});
        end
        rst_n = 1'b1;
        step();
        nAssert++;
        if (instr_ready !== 1'b1) begin
            nFail++; $display("FAIL reset_ready_after_release: got %b expected 1", instr_ready);
        end
    endtask

    task automatic test_basic_writeback();
        runInstr(5'd3, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 16'h1333, 0, 1'b0);
        nAssert++;
        if ({obsReA, obsReB, obsAddrA} !== {1'b1, 1'b1, 5'd3}) begin
            nFail++; $display("FAIL basic_read_enables: got %b%b addr %0d expected 11 addr 3", obsReA, obsReB, obsAddrA);
        end
        nAssert++;
        if ({obsOpValid3, obsOpA, obsOpB} !== {1'b1, 16'h1234, 16'h00FF}) begin
            nFail++; $display("FAIL basic_operands: got v=%b %h %h expected v=1 1234 00ff", obsOpValid3, obsOpA, obsOpB);
        end
        nAssert++;
        if ({obsOpValidAfter, obsResReady} !== 2'b01) begin
            nFail++; $display("FAIL basic_handshake: got op_valid=%b res_ready=%b expected 0 1", obsOpValidAfter, obsResReady);
        end
        nAssert++;
        if (strobes != 1 || weAddr !== 5'd7 || weData !== 16'h1333) begin
            nFail++; $display("FAIL basic_strobe: got %0d strobes addr %0d data %h expected 1 7 1333", strobes, weAddr, weData);
        end
        nAssert++;
        if (weStable !== 1'b1 || overlap !== 1'b0) begin
            nFail++; $display("FAIL basic_strobe_setup: got stable=%b overlap=%b expected 1 0", weStable, overlap);
        end
        nAssert++;
        if (postAddr !== 5'd7 || postData !== 16'h1333 || postReady !== 1'b1) begin
            nFail++; $display("FAIL basic_hold: got %0d %h rdy=%b expected 7 1333 1", postAddr, postData, postReady);
        end
        nAssert++;
        if (mem[7] !== 16'h1333) begin
            nFail++; $display("FAIL basic_regfile: got %h expected 1333", mem[7]);
        end
    endtask

    task automatic test_no_use_b();
        runInstr(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b0, 16'h7777, 0, 1'b0);
        nAssert++;
        if (reBSeen !== 1'b0) begin
            nFail++; $display("FAIL nouseb_regReB: got %b expected 0", reBSeen);
        end
        nAssert++;
        if (obsOpA !== 16'h1234 || obsOpB !== 16'h0000) begin
            nFail++; $display("FAIL nouseb_operands: got %h %h expected 1234 0000", obsOpA, obsOpB);
        end
        nAssert++;
        if (strobes != 0 || mem[4] !== 16'h0000) begin
            nFail++; $display("FAIL nouseb_no_write: got %0d strobes mem4=%h expected 0 0000", strobes, mem[4]);
        end
    endtask

    task automatic test_rd_zero();
        runInstr(5'd5, 5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 16'hBEEF, 0, 1'b0);
        nAssert++;
        if (strobes != 0) begin
            nFail++; $display("FAIL rdzero_strobe: got %0d strobes expected 0", strobes);
        end
        nAssert++;
        if (obsReadyAfterRes !== 1'b1) begin
            nFail++; $display("FAIL rdzero_ready: got %b expected 1", obsReadyAfterRes);
        end
        nAssert++;
        if (obsOpA !== 16'h00FF || obsOpB !== 16'h1234) begin
            nFail++; $display("FAIL rdzero_operands: got %h %h expected 00ff 1234", obsOpA, obsOpB);
        end
    endtask

    task automatic test_op_stall();
        runInstr(5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 16'h0001, 4, 1'b0);
        nAssert++;
        if (stableOk !== 1'b1 || obsOpA !== 16'h00FF || obsOpB !== 16'h1234) begin
            nFail++; $display("FAIL stall_stable: got stable=%b %h %h expected 1 00ff 1234", stableOk, obsOpA, obsOpB);
        end
        nAssert++;
        if (readyBusy !== 1'b0) begin
            nFail++; $display("FAIL stall_ready_busy: got %b expected 0", readyBusy);
        end
        step(); step();
        nAssert++;
        if (regReA !== 1'b0 || instr_ready !== 1'b1 || op_valid !== 1'b0) begin
            nFail++; $display("FAIL stall_ghost_instr: got reA=%b rdy=%b opv=%b expected 0 1 0", regReA, instr_ready, op_valid);
        end
    endtask

    task automatic test_back_to_back();
        runInstr(5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1, 16'h0042, 0, 1'b0);
        nAssert++;
        if (mem[9] !== 16'h0042) begin
            nFail++; $display("FAIL b2b_first_write: got %h expected 0042", mem[9]);
        end
        runInstr(5'd9, 5'd0, 5'd10, 1'b1, 1'b1, 1'b1, 16'h0043, 0, 1'b0);
        nAssert++;
        if (obsOpA !== 16'h0042 || obsOpB !== 16'h0000) begin
            nFail++; $display("FAIL b2b_forward: got %h %h expected 0042 0000", obsOpA, obsOpB);
        end
    endtask

    task automatic test_reset_mid_strobe();
        runInstr(5'd3, 5'd5, 5'd12, 1'b1, 1'b1, 1'b1, 16'hA5A5, 0, 1'b1);
        nAssert++;
        if (regWeD !== 1'b1) begin
            nFail++; $display("FAIL midrst_reach_strobe: got %b expected 1", regWeD);
        end
        #1 rst_n = 1'b0;
        #1;
        nAssert++;
        if ({regWeD, regReA, regReB, instr_ready} !== 4'b0000) begin
            nFail++; $display("FAIL midrst_async_drop: got %b expected 0000", {regWeD, regReA, regReB, instr_ready});
        end
        step(); step();
        rst_n = 1'b1;
        step(); step(); step(); step();
        nAssert++;
        if (strobes != 1) begin
            nFail++; $display("FAIL midrst_extra_strobe: got %0d strobes expected 1", strobes);
        end
        nAssert++;
        if (instr_ready !== 1'b1 || op_valid !== 1'b0 || res_ready !== 1'b0) begin
            nFail++; $display("FAIL midrst_idle: got rdy=%b opv=%b resr=%b expected 1 0 0", instr_ready, op_valid, res_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic_writeback();
        test_no_use_b();
        test_rd_zero();
        test_op_stall();
        test_back_to_back();
        test_reset_mid_strobe();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
